keccak_msg_feeder: RTL

//  Drives the keccak core's word input from an upstream byte stream and drains the core's digest.

---
 rtl/keccak_msg_feeder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_msg_feeder.sv
// Byte-stream to keccak word feeder with digest serializer.
// Optional abort input is enabled by defining KECCAK_FEEDER_ABORT_EN.
module keccak_msg_feeder #(
    parameter int unsigned DIGEST_BYTES = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   s_byte,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic         k_reset,
    output logic [31:0]  k_in,
    output logic         k_in_ready,
    output logic         k_is_last,
    output logic [1:0]   k_byte_num,
    input  logic         k_buffer_full,
    input  logic [511:0] k_out,
    input  logic         k_out_ready,
    output logic [7:0]   d_data,
    output logic         d_valid,
    output logic         d_last,
    input  logic         d_ready
`ifdef KECCAK_FEEDER_ABORT_EN
   ,input  logic         abort
`endif
);
    localparam int unsigned DW = 8 * DIGEST_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE, ST_KRST, ST_FILL, ST_SEND, ST_PAD, ST_WAIT, ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [6:0]      dcnt_q, dcnt_d;
    logic            pend_q, pend_d;
    logic            s_ready_q, s_ready_d;
    logic            k_reset_q, k_reset_d;
    logic            k_in_ready_q, k_in_ready_d;
    logic            k_is_last_q, k_is_last_d;
    logic [1:0]      k_byte_num_q, k_byte_num_d;
    logic            d_valid_q, d_valid_d;
    logic            d_last_q, d_last_d;
    logic [1:0]      lane;
    logic            abort_req;
    logic            part_last;

`ifdef KECCAK_FEEDER_ABORT_EN
    assign abort_req = abort && (state_q != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign lane = 2'd3 - cnt_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        last_d  = last_q;
        dig_d   = dig_q;
        dcnt_d  = dcnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) state_d = ST_KRST;
            end
            ST_KRST: begin
                state_d = pend_q ? ST_IDLE : ST_FILL;
                pend_d  = 1'b0;
                cnt_d   = 3'd0;
                word_d  = '0;
                last_d  = 1'b0;
            end
            ST_FILL: begin
                if (s_valid) begin
                    word_d[{lane, 3'b000} +: 8] = s_byte;
                    cnt_d  = cnt_q + 3'd1;
                    last_d = s_last;
                    if (cnt_q == 3'd3 || s_last) state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!k_buffer_full) begin
                    // Every exit from SEND wants a clean word: FILL reuses it, PAD sends zero.
                    word_d = '0;
                    cnt_d  = 3'd0;
                    if (!last_q)               state_d = ST_FILL;
                    else if (cnt_q == 3'd4)    state_d = ST_PAD;
                    else                       state_d = ST_WAIT;
                end
            end
            ST_PAD: begin
                if (!k_buffer_full) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (k_out_ready) begin
                    dig_d   = k_out[511 -: DW];
                    dcnt_d  = 7'd0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (d_valid_q && d_ready) begin
                    dig_d  = dig_q << 8;
                    dcnt_d = dcnt_q + 7'd1;
                    if (dcnt_q == 7'(DIGEST_BYTES - 1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_req) begin
            state_d = ST_KRST;
            pend_d  = 1'b1;
            cnt_d   = 3'd0;
            word_d  = '0;
            last_d  = 1'b0;
            dig_d   = '0;
            dcnt_d  = 7'd0;
        end

        // Outputs are registered copies of what the next state will present.
        part_last    = (state_d == ST_SEND) && last_d && (cnt_d != 3'd4);
        s_ready_d    = (state_d == ST_FILL);
        k_reset_d    = (state_d == ST_KRST);
        k_in_ready_d = (state_d == ST_SEND) || (state_d == ST_PAD);
        k_is_last_d  = part_last || (state_d == ST_PAD);
        k_byte_num_d = part_last ? cnt_d[1:0] : 2'd0;
        d_valid_d    = (state_d == ST_DRAIN);
        d_last_d     = (state_d == ST_DRAIN) && (dcnt_d == 7'(DIGEST_BYTES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            word_q       <= '0;
            last_q       <= 1'b0;
            dig_q        <= '0;
            dcnt_q       <= 7'd0;
            pend_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            k_reset_q    <= 1'b1;
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= 2'd0;
            d_valid_q    <= 1'b0;
            d_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            last_q       <= last_d;
            dig_q        <= dig_d;
            dcnt_q       <= dcnt_d;
            pend_q       <= pend_d;
            s_ready_q    <= s_ready_d;
            k_reset_q    <= k_reset_d;
            k_in_ready_q <= k_in_ready_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
            d_valid_q    <= d_valid_d;
            d_last_q     <= d_last_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign k_reset    = k_reset_q;
    assign k_in       = word_q;
    assign k_in_ready = k_in_ready_q;
    assign k_is_last  = k_is_last_q;
    assign k_byte_num = k_byte_num_q;
    assign d_data     = dig_q[DW-1 -: 8];
    assign d_valid    = d_valid_q;
    assign d_last     = d_last_q;

endmodule
